// File: rtl/mmio_responder.sv
`timescale 1ns/1ps
// mmio_responder
// ----------------------------------------------------------------------------
// Memory-port responder placed between the multicycle CPU and the word RAM
// (Memoria). Each access is decoded either to a 256-byte local I/O window or
// forwarded to the RAM. Reads from both targets return one cycle after the
// address, so the CPU sees a uniform one-cycle latency.
//
// I/O window (offsets from IO_BASE):
//   0x00 CONSOLE  write pushes Datain[7:0] into the transmit FIFO, reads 0
//   0x04 STATUS   {count at bit 8+, drop_sticky, full, empty}; write bit2 clears drop
//   0x08 CYCLE    free-running cycle counter (only with MMIO_CYCLE_COUNTER_EN)
//   0x0C SCRATCH  32-bit read/write
//   other         reads 0, writes ignored
//
// Optional feature macro: MMIO_CYCLE_COUNTER_EN
//   defined   : CYCLE register present (loadable, wrapping counter)
//   undefined : no counter, offset 0x08 reads 0 and ignores writes
//
// Ports:
//   Clk, reset          clock and synchronous active-high reset
//   Address, wr, Datain CPU memory port request
//   Dataout             read data to the CPU (1-cycle latency)
//   ram_wr, ram_dataout Memoria write strobe / registered read data
//   tx_data, tx_valid   console stream out (head byte, FIFO not empty)
//   tx_ready            console consumer accepts the head byte
// ----------------------------------------------------------------------------
module mmio_responder #(
   parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
   parameter int          FIFO_DEPTH = 8,
   parameter int          CNT_W      = 4
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic        wr,
   input  logic [31:0] Datain,
   output logic [31:0] Dataout,
   output logic        ram_wr,
   input  logic [31:0] ram_dataout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   // ---------------- decode ----------------
   logic       io_hit;
   logic [5:0] reg_idx;
   logic       wr_console;
   logic       wr_status;
   logic       wr_scratch;
   logic       unused_addr_lsb;

   assign io_hit          = (Address[31:8] == IO_BASE[31:8]);
   assign reg_idx         = Address[7:2];
   assign unused_addr_lsb = ^Address[1:0];   // byte lane bits carry no meaning here

   assign ram_wr     = wr & ~io_hit;
   assign wr_console = wr & io_hit & (reg_idx == 6'd0);
   assign wr_status  = wr & io_hit & (reg_idx == 6'd1);
   assign wr_scratch = wr & io_hit & (reg_idx == 6'd3);

   // ---------------- console FIFO ----------------
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             drop_sticky_reg;
   logic             fifo_full;
   logic             fifo_empty;
   logic             do_pop;
   logic             do_push;
   logic             do_drop;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == DEPTH_C);
   assign tx_valid   = ~fifo_empty;
   assign tx_data    = fifo_mem[rd_ptr_reg];

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign do_pop  = tx_valid & tx_ready;
   assign do_push = wr_console & (~fifo_full | do_pop);
   assign do_drop = wr_console & fifo_full & ~do_pop;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge Clk) begin
      if (!reset && do_push) begin
         fifo_mem[wr_ptr_reg] <= Datain[7:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         count_reg       <= '0;
         drop_sticky_reg <= 1'b0;
      end else begin
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         // A fresh drop wins over a clear issued in the same cycle.
         if (do_drop) begin
            drop_sticky_reg <= 1'b1;
         end else if (wr_status && Datain[2]) begin
            drop_sticky_reg <= 1'b0;
         end
      end
   end

   // ---------------- scratch ----------------
   logic [31:0] scratch_reg;

   always_ff @(posedge Clk) begin
      if (reset) begin
         scratch_reg <= '0;
      end else if (wr_scratch) begin
         scratch_reg <= Datain;
      end
   end

   // ---------------- cycle counter ----------------
   logic [31:0] cycle_rdata;

`ifdef MMIO_CYCLE_COUNTER_EN
   logic        wr_cycle;
   logic [31:0] cycle_reg;

   assign wr_cycle = wr & io_hit & (reg_idx == 6'd2);

   // A load takes priority; counting resumes on the following edge.
   always_ff @(posedge Clk) begin
      if (reset) begin
         cycle_reg <= '0;
      end else if (wr_cycle) begin
         cycle_reg <= Datain;
      end else begin
         cycle_reg <= cycle_reg + 32'd1;
      end
   end

   assign cycle_rdata = cycle_reg;
`else
   assign cycle_rdata = '0;
`endif

   // ---------------- local read mux and return path ----------------
   logic [31:0] status_word;
   logic [31:0] io_rdata;
   logic        sel_reg;
   logic [31:0] io_rdata_reg;

   always_comb begin
      status_word              = '0;
      status_word[8 +: CNT_W]  = count_reg;
      status_word[2]           = drop_sticky_reg;
      status_word[1]           = fifo_full;
      status_word[0]           = fifo_empty;
   end

   always_comb begin
      io_rdata = '0;
      if (io_hit) begin
         case (reg_idx)
            6'd1:    io_rdata = status_word;
            6'd2:    io_rdata = cycle_rdata;
            6'd3:    io_rdata = scratch_reg;
            default: io_rdata = '0;
         endcase
      end
   end

   // Registering the local data matches Memoria's one-cycle read latency.
   always_ff @(posedge Clk) begin
      if (reset) begin
         sel_reg      <= 1'b0;
         io_rdata_reg <= '0;
      end else begin
         sel_reg      <= io_hit;
         io_rdata_reg <= io_rdata;
      end
   end

   assign Dataout = sel_reg ? io_rdata_reg : ram_dataout;

endmodule

// File: tb/tb_mmio_responder.sv
`timescale 1ns/1ps
// tb_mmio_responder
// Scoreboard bench: expected read data is queued when a read is issued and
// compared when Dataout becomes valid; a byte queue models the console FIFO.
module tb_mmio_responder;

   localparam logic [31:0] IO_BASE    = 32'hFFFF_FF00;
   localparam int          FIFO_DEPTH = 8;
   localparam logic [31:0] RAM_VAL    = 32'h1234_5678;
   localparam logic [31:0] IDLE_ADDR  = 32'h0000_0100;

   logic        Clk;
   logic        reset;
   logic [31:0] Address;
   logic        wr;
   logic [31:0] Datain;
   logic [31:0] Dataout;
   logic        ram_wr;
   logic [31:0] ram_dataout;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic [7:0]  tx_q  [$];
   bit          model_drop;

   mmio_responder #(
      .IO_BASE    (IO_BASE),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (4)
   ) dut (
      .Clk         (Clk),
      .reset       (reset),
      .Address     (Address),
      .wr          (wr),
      .Datain      (Datain),
      .Dataout     (Dataout),
      .ram_wr      (ram_wr),
      .ram_dataout (ram_dataout),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic full;
      logic empty;
      logic [3:0] cnt;
      cnt   = 4'(tx_q.size());
      full  = (tx_q.size() == FIFO_DEPTH);
      empty = (tx_q.size() == 0);
      return {16'b0, 4'b0, cnt, 5'b0, model_drop, full, empty};
   endfunction

   // One bus cycle: drive at the falling edge, check combinational outputs
   // before the rising edge, update the model at it, check read data after.
   task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic rd, input logic [31:0] exp, input string tag);
      bit io;
      bit is_console;
      bit mpop;
      bit mpush;
      Address = a;
      wr      = w;
      Datain  = d;
      if (rd) begin
         exp_q.push_back(exp);
         tag_q.push_back(tag);
      end
      $display("txn %-12s addr=%h wr=%0d data=%h rd=%0d", tag, a, w, d, rd);
      #1;
      io         = (a[31:8] == IO_BASE[31:8]);
      is_console = w && io && (a[7:2] == 6'd0);
      check({tag, ":ram_wr"},   {31'b0, ram_wr},   {31'b0, (w && !io)});
      check({tag, ":tx_valid"}, {31'b0, tx_valid}, {31'b0, (tx_q.size() != 0)});
      mpop  = tx_ready && (tx_q.size() != 0);
      mpush = is_console && ((tx_q.size() < FIFO_DEPTH) || mpop);
      @(posedge Clk);
      if (mpop) void'(tx_q.pop_front());
      if (mpush) tx_q.push_back(d[7:0]);
      if (is_console && !mpush) model_drop = 1'b1;
      else if (w && io && (a[7:2] == 6'd1) && d[2]) model_drop = 1'b0;
      @(negedge Clk);
      wr = 1'b0;
      if (exp_q.size() > 0) begin
         string t;
         logic [31:0] e;
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         check({t, ":Dataout"}, Dataout, e);
      end
   endtask

   task automatic stream(input int n);
      tx_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         check($sformatf("tx_data[%0d]", i), {24'b0, tx_data}, {24'b0, tx_q[0]});
         bus(IDLE_ADDR, 1'b0, 32'h0, 1'b0, 32'h0, "idle");
      end
   endtask

   initial begin
      reset       = 1'b1;
      Address     = IDLE_ADDR;
      wr          = 1'b0;
      Datain      = '0;
      tx_ready    = 1'b0;
      ram_dataout = RAM_VAL;
      model_drop  = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      reset = 1'b0;

      // reset state
      check("rst:tx_valid", {31'b0, tx_valid}, 32'd0);
      check("rst:Dataout", Dataout, RAM_VAL);
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, exp_status(), "rst_status");

      // RAM forwarding
      bus(32'h0000_0010, 1'b0, 32'h0, 1'b1, RAM_VAL, "ram_rd");
      bus(32'h0000_0010, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0, "ram_wr");
      bus(32'hFFFF_FF0C, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, "scr_wr");

      // scratch and unmapped offsets
      bus(32'hFFFF_FF0C, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, "scr_rd");
      bus(32'hFFFF_FF0F, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, "scr_rd_lsb");
      bus(32'hFFFF_FF40, 1'b0, 32'h0, 1'b1, 32'h0, "unmapped_rd");
      bus(32'hFFFF_FF40, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, "unmapped_wr");
      bus(32'hFFFF_FF00, 1'b0, 32'h0, 1'b1, 32'h0, "console_rd");

      // fill, overflow, clear drop, drain
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         bus(IO_BASE, 1'b1, 32'h41 + i, 1'b0, 32'h0, "push");
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, 32'h0000_0802, "st_full");
      bus(IO_BASE, 1'b1, 32'h49, 1'b0, 32'h0, "push_drop");
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, exp_status(), "st_drop");
      bus(IO_BASE + 32'h04, 1'b1, 32'h4, 1'b0, 32'h0, "st_clr");
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, 32'h0000_0802, "st_cleared");
      stream(8);
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, 32'h0000_0001, "st_empty");

      // full + push + pop in one cycle
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         bus(IO_BASE, 1'b1, 32'h51 + i, 1'b0, 32'h0, "push");
      tx_ready = 1'b1;
      bus(IO_BASE, 1'b1, 32'h5A, 1'b0, 32'h0, "push_pop");
      tx_ready = 1'b0;
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, 32'h0000_0802, "st_pushpop");
      check("last_byte", {24'b0, tx_q[7]}, 32'h5A);
      stream(8);
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, 32'h0000_0001, "st_empty2");

      // cycle counter: load then observe three consecutive reads
      bus(IO_BASE + 32'h08, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, "cyc_wr");
`ifdef MMIO_CYCLE_COUNTER_EN
      bus(IO_BASE + 32'h08, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, "cyc_rd0");
      bus(IO_BASE + 32'h08, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, "cyc_rd1");
      bus(IO_BASE + 32'h08, 1'b0, 32'h0, 1'b1, 32'h0000_0000, "cyc_wrap");
`else
      bus(IO_BASE + 32'h08, 1'b0, 32'h0, 1'b1, 32'h0, "cyc_rd0");
      bus(IO_BASE + 32'h08, 1'b0, 32'h0, 1'b1, 32'h0, "cyc_rd1");
      bus(IO_BASE + 32'h08, 1'b0, 32'h0, 1'b1, 32'h0, "cyc_wrap");
`endif

      // reset in the middle of a transfer, with a write in the reset cycle
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         bus(IO_BASE, 1'b1, 32'h61 + i, 1'b0, 32'h0, "push");
      bus(IO_BASE + 32'h0C, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, "scr_pre_rst");
      reset    = 1'b1;
      tx_ready = 1'b1;
      Address  = IO_BASE + 32'h0C;
      wr       = 1'b1;
      Datain   = 32'h1111_1111;
      $display("txn %-12s addr=%h wr=1 data=%h", "reset", Address, Datain);
      @(posedge Clk);
      @(negedge Clk);
      reset = 1'b0;
      wr    = 1'b0;
      tx_q.delete();
      model_drop = 1'b0;
      check("mid_rst:tx_valid", {31'b0, tx_valid}, 32'd0);
      check("mid_rst:Dataout", Dataout, RAM_VAL);
      bus(IO_BASE + 32'h04, 1'b0, 32'h0, 1'b1, 32'h0000_0001, "st_after_rst");
      bus(IO_BASE + 32'h0C, 1'b0, 32'h0, 1'b1, 32'h0, "scr_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
